// File: rtl/ip_stream_dispatcher.sv
// Routes AXI-Stream packets to one of IP_AMT image-processor lanes by first-beat
// tdest, and merges per-lane hog_svm result pulses into one FWFT result stream.
module ip_stream_dispatcher #(
  parameter int unsigned IP_AMT       = 4,
  parameter int unsigned IP_ADDR_W    = $clog2(IP_AMT),
  parameter int unsigned AXIS_TDEST_W = IP_ADDR_W,
  parameter int unsigned AXIS_TDATA_W = 256,
  parameter int unsigned SW_W         = 11,
  parameter int unsigned RES_DEPTH    = 8
) (
  input  logic                           s_aclk,
  input  logic                           rst,
  input  logic [AXIS_TDEST_W-1:0]        s_tdest_i,
  input  logic [AXIS_TDATA_W-1:0]        s_tdata_i,
  input  logic                           s_tlast_i,
  input  logic                           s_tvalid_i,
  output logic                           s_tready_o,
  output logic [IP_AMT*AXIS_TDATA_W-1:0] m_tdata_o,
  output logic [IP_AMT-1:0]              m_tlast_o,
  output logic [IP_AMT-1:0]              m_tvalid_o,
  input  logic [IP_AMT-1:0]              m_tready_i,
  input  logic [IP_AMT-1:0]              res_valid_i,
  input  logic [IP_AMT-1:0]              res_person_i,
  input  logic [IP_AMT*SW_W-1:0]         res_swid_i,
  output logic                           res_valid_o,
  output logic                           res_person_o,
  output logic [SW_W-1:0]                res_swid_o,
  output logic [IP_ADDR_W-1:0]           res_lane_o,
  input  logic                           res_ready_i,
  output logic [15:0]                    err_cnt_o,
  output logic [IP_AMT-1:0]              ovf_o
);

  localparam int unsigned FIFO_AW = $clog2(RES_DEPTH);
  localparam int unsigned CNT_W   = FIFO_AW + 1;
  localparam int unsigned ENTRY_W = IP_ADDR_W + 1 + SW_W;

  typedef enum logic [1:0] {IDLE, ROUTE, SINK} state_t;

  // ---------------------------------------------------------------- input side
  state_t                   state_q, state_d;
  logic [IP_ADDR_W-1:0]     lane_q;
  logic [IP_ADDR_W-1:0]     cur_lane;
  logic                     in_range;
  logic                     lane_ok;
  logic                     accept;
  logic                     route_beat;
  logic                     discard_first;
  logic [IP_AMT-1:0]        lane_hit;
  logic [IP_AMT-1:0]        lane_free;
  logic [IP_AMT-1:0]        m_valid_q;
  logic [IP_AMT-1:0]        m_last_q;
  logic [AXIS_TDATA_W-1:0]  m_data_q [IP_AMT];
  logic [15:0]              err_q;

  // In IDLE the lane comes straight from tdest; afterwards it is the latched lane
  assign cur_lane = (state_q == IDLE) ? IP_ADDR_W'(s_tdest_i) : lane_q;
  assign in_range = (state_q == IDLE)  ? (32'(s_tdest_i) < IP_AMT) :
                    (state_q == ROUTE);

  // Per-lane decode of the target lane and of its output register having room
  for (genvar k = 0; k < IP_AMT; k++) begin : g_lane
    assign lane_hit[k]  = (cur_lane == IP_ADDR_W'(k));
    assign lane_free[k] = ~m_valid_q[k] | m_tready_i[k];
    assign m_tdata_o[k*AXIS_TDATA_W +: AXIS_TDATA_W] = m_data_q[k];
  end

  assign lane_ok    = |(lane_hit & lane_free);
  assign m_tvalid_o = m_valid_q;
  assign m_tlast_o  = m_last_q;
  assign err_cnt_o  = err_q;

  // Input FSM state register
  always_ff @(posedge s_aclk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Input FSM next state, ready and beat classification
  always_comb begin
    state_d       = state_q;
    s_tready_o    = 1'b0;
    accept        = 1'b0;
    route_beat    = 1'b0;
    discard_first = 1'b0;
    unique case (state_q)
      IDLE:    s_tready_o = in_range ? lane_ok : 1'b1;
      ROUTE:   s_tready_o = lane_ok;
      SINK:    s_tready_o = 1'b1;
      default: s_tready_o = 1'b0;
    endcase
    if (rst) s_tready_o = 1'b0;
    accept     = s_tvalid_i & s_tready_o;
    route_beat = accept & in_range;
    if (accept) begin
      unique case (state_q)
        IDLE: begin
          discard_first = ~in_range;
          if (!s_tlast_i) state_d = in_range ? ROUTE : SINK;
        end
        ROUTE, SINK: if (s_tlast_i) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Packet lane latch and discarded-packet counter (saturating)
  always_ff @(posedge s_aclk) begin
    if (rst) begin
      lane_q <= '0;
      err_q  <= '0;
    end else begin
      if (accept && state_q == IDLE) lane_q <= cur_lane;
      if (discard_first && err_q != 16'hFFFF) err_q <= err_q + 16'd1;
    end
  end

  // Per-lane output registers: load on routed beat, clear on drain
  always_ff @(posedge s_aclk) begin
    if (rst) begin
      m_valid_q <= '0;
    end else begin
      for (int k = 0; k < IP_AMT; k++) begin
        if (route_beat && lane_hit[k]) begin
          m_valid_q[k] <= 1'b1;
          m_last_q[k]  <= s_tlast_i;
          m_data_q[k]  <= s_tdata_i;
        end else if (m_tready_i[k]) begin
          m_valid_q[k] <= 1'b0;
        end
      end
    end
  end

  // --------------------------------------------------------------- result side
  logic [IP_AMT-1:0]     pend_q;
  logic [IP_AMT-1:0]     pend_person_q;
  logic [SW_W-1:0]       pend_swid_q [IP_AMT];
  logic [IP_AMT-1:0]     ovf_q;
  logic [IP_AMT-1:0]     grant;
  logic                  gnt_any;
  logic [IP_ADDR_W-1:0]  gnt_idx;
  logic [IP_ADDR_W-1:0]  ptr_q;
  int unsigned           rr_idx;
  logic [ENTRY_W-1:0]    fifo_mem [RES_DEPTH];
  logic [FIFO_AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic                  fifo_full;
  logic                  fifo_can_push;
  logic                  pop;

  assign fifo_full     = (count_q == CNT_W'(RES_DEPTH));
  assign res_valid_o   = (count_q != '0) & ~rst;
  assign pop           = res_valid_o & res_ready_i;
  assign fifo_can_push = ~fifo_full | pop;
  assign {res_lane_o, res_person_o, res_swid_o} = fifo_mem[rd_ptr_q];
  assign ovf_o         = ovf_q;

  // Round-robin grant of one pending lane, scanning from the pointer
  always_comb begin
    grant   = '0;
    gnt_any = 1'b0;
    gnt_idx = ptr_q;
    rr_idx  = 0;
    for (int i = 0; i < IP_AMT; i++) begin
      rr_idx = (32'(ptr_q) + 32'(i)) % IP_AMT;
      if (!gnt_any && pend_q[IP_ADDR_W'(rr_idx)] && fifo_can_push) begin
        grant[IP_ADDR_W'(rr_idx)] = 1'b1;
        gnt_any                   = 1'b1;
        gnt_idx                   = IP_ADDR_W'(rr_idx);
      end
    end
  end

  // Pending capture per lane; a pulse onto an ungranted pending entry overflows
  always_ff @(posedge s_aclk) begin
    if (rst) begin
      pend_q <= '0;
      ovf_q  <= '0;
      ptr_q  <= '0;
    end else begin
      for (int k = 0; k < IP_AMT; k++) begin
        if (res_valid_i[k]) begin
          if (pend_q[k] && !grant[k]) begin
            ovf_q[k] <= 1'b1;
          end else begin
            pend_q[k]        <= 1'b1;
            pend_person_q[k] <= res_person_i[k];
            pend_swid_q[k]   <= res_swid_i[k*SW_W +: SW_W];
          end
        end else if (grant[k]) begin
          pend_q[k] <= 1'b0;
        end
      end
      if (gnt_any)
        ptr_q <= (32'(gnt_idx) == IP_AMT - 1) ? '0 : gnt_idx + IP_ADDR_W'(1);
    end
  end

  // Result FIFO storage
  always_ff @(posedge s_aclk) begin
    if (gnt_any) fifo_mem[wr_ptr_q] <= {gnt_idx, pend_person_q[gnt_idx], pend_swid_q[gnt_idx]};
  end

  // Result FIFO pointers and occupancy
  always_ff @(posedge s_aclk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (gnt_any) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      if (gnt_any && !pop)      count_q <= count_q + CNT_W'(1);
      else if (!gnt_any && pop) count_q <= count_q - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ip_stream_dispatcher.sv
// Bench for ip_stream_dispatcher: vector table for the stream path, directed
// result-merge sequences, and a randomized packet run against a lane-queue model.
module tb_ip_stream_dispatcher;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 11;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      s_tdest;
  logic [DW-1:0]   s_tdata;
  logic            s_tlast, s_tvalid, s_tready;
  logic [N*DW-1:0] m_tdata;
  logic [N-1:0]    m_tlast, m_tvalid, m_tready;
  logic [N-1:0]    res_valid_in, res_person_in;
  logic [N*SW-1:0] res_swid_in;
  logic            res_valid_out, res_person_out, res_ready;
  logic [SW-1:0]   res_swid_out;
  logic [1:0]      res_lane_out;
  logic [15:0]     err_cnt;
  logic [N-1:0]    ovf;

  always #5 clk = ~clk;

  ip_stream_dispatcher #(
    .IP_AMT(N), .AXIS_TDEST_W(4), .AXIS_TDATA_W(DW), .SW_W(SW), .RES_DEPTH(8)
  ) dut (
    .s_aclk(clk), .rst(rst),
    .s_tdest_i(s_tdest), .s_tdata_i(s_tdata), .s_tlast_i(s_tlast),
    .s_tvalid_i(s_tvalid), .s_tready_o(s_tready),
    .m_tdata_o(m_tdata), .m_tlast_o(m_tlast), .m_tvalid_o(m_tvalid), .m_tready_i(m_tready),
    .res_valid_i(res_valid_in), .res_person_i(res_person_in), .res_swid_i(res_swid_in),
    .res_valid_o(res_valid_out), .res_person_o(res_person_out), .res_swid_o(res_swid_out),
    .res_lane_o(res_lane_out), .res_ready_i(res_ready),
    .err_cnt_o(err_cnt), .ovf_o(ovf)
  );

  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        tv;
    logic [3:0]  dest;
    logic [31:0] data;
    logic        last;
    logic [3:0]  mrdy;
    logic        srdy;
    logic [3:0]  mv;
    int          lane;
    logic [31:0] md;
    logic        ml;
    logic [15:0] err;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic tv, input logic [3:0] dest, input logic [31:0] data,
                              input logic last, input logic [3:0] mrdy, input logic srdy,
                              input logic [3:0] mv, input int lane, input logic [31:0] md,
                              input logic ml, input logic [15:0] err);
    vec_t v;
    v.tv = tv; v.dest = dest; v.data = data; v.last = last; v.mrdy = mrdy; v.srdy = srdy;
    v.mv = mv; v.lane = lane; v.md = md; v.ml = ml; v.err = err;
    return v;
  endfunction

  task automatic idle_inputs();
    s_tvalid = 1'b0; s_tdest = '0; s_tdata = '0; s_tlast = 1'b0; m_tready = 4'hF;
    res_valid_in = '0; res_person_in = '0; res_swid_in = '0; res_ready = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic chk_res(input string name, input int lane, input int swid, input logic person);
    check({name, "_valid"}, 64'(res_valid_out), 64'd1);
    check({name, "_lane"}, 64'(res_lane_out), 64'(lane));
    check({name, "_swid"}, 64'(res_swid_out), 64'(swid));
    check({name, "_person"}, 64'(res_person_out), 64'(person));
  endtask

  // Randomized-run model: expected beats tagged {lane, last, data}, per-lane order
  logic [34:0] exp_q[$];
  int          err_exp;
  bit          done;

  task automatic send_beat(input logic [3:0] dest, input logic [31:0] data, input logic last);
    bit acc;
    int wc;
    s_tvalid = 1'b1; s_tdest = dest; s_tdata = data; s_tlast = last;
    acc = 1'b0; wc = 0;
    while (!acc && wc < 200) begin
      @(negedge clk);
      acc = s_tready;
      tick();
      wc++;
    end
    if (!acc) check("accept_timeout", 64'd0, 64'd1);
    s_tvalid = 1'b0;
  endtask

  initial begin
    int len, dest, wc;
    logic [31:0] d;
    logic [3:0]  td;
    logic        l;

    // ---------------- reset behaviour
    idle_inputs();
    rst = 1'b1;
    s_tvalid = 1'b1;
    #2;
    check("rst_s_tready", 64'(s_tready), 64'd0);
    tick(); tick();
    check("rst_s_tready_held", 64'(s_tready), 64'd0);
    check("rst_res_valid", 64'(res_valid_out), 64'd0);
    check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_err_cnt", 64'(err_cnt), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    s_tvalid = 1'b0;
    rst = 1'b0;

    // ---------------- stream vector table
    // 3-beat packet to lane 2
    vq.push_back(mk(1, 2, 32'hA1, 0, 4'hF, 1, 4'b0100, 2, 32'hA1, 0, 0));
    vq.push_back(mk(1, 2, 32'hA2, 0, 4'hF, 1, 4'b0100, 2, 32'hA2, 0, 0));
    vq.push_back(mk(1, 2, 32'hA3, 1, 4'hF, 1, 4'b0100, 2, 32'hA3, 1, 0));
    vq.push_back(mk(0, 0, 32'h0,  0, 4'hF, 1, 4'b0000, 0, 32'h0,  0, 0));
    // later-beat tdest ignored
    vq.push_back(mk(1, 1, 32'hB1, 0, 4'hF, 1, 4'b0010, 1, 32'hB1, 0, 0));
    vq.push_back(mk(1, 3, 32'hB2, 1, 4'hF, 1, 4'b0010, 1, 32'hB2, 1, 0));
    vq.push_back(mk(0, 0, 32'h0,  0, 4'hF, 1, 4'b0000, 0, 32'h0,  0, 0));
    // out-of-range 4-beat packet is sunk, counted once
    vq.push_back(mk(1, 5, 32'hC1, 0, 4'hF, 1, 4'b0000, 0, 32'h0,  0, 1));
    vq.push_back(mk(1, 5, 32'hC2, 0, 4'hF, 1, 4'b0000, 0, 32'h0,  0, 1));
    vq.push_back(mk(1, 0, 32'hC3, 0, 4'hF, 1, 4'b0000, 0, 32'h0,  0, 1));
    vq.push_back(mk(1, 2, 32'hC4, 1, 4'hF, 1, 4'b0000, 0, 32'h0,  0, 1));
    // single-beat packets: lane 0, then out of range
    vq.push_back(mk(1, 0, 32'hD1, 1, 4'hF, 1, 4'b0001, 0, 32'hD1, 1, 1));
    vq.push_back(mk(1, 15, 32'hD2, 1, 4'hF, 1, 4'b0000, 0, 32'h0, 0, 2));
    vq.push_back(mk(0, 0, 32'h0,  0, 4'hF, 1, 4'b0000, 0, 32'h0,  0, 2));
    // lane 0 backpressure, then drain and refill in one cycle
    vq.push_back(mk(1, 0, 32'hE1, 0, 4'hE, 1, 4'b0001, 0, 32'hE1, 0, 2));
    vq.push_back(mk(1, 0, 32'hE2, 1, 4'hE, 0, 4'b0001, 0, 32'hE1, 0, 2));
    vq.push_back(mk(1, 0, 32'hE2, 1, 4'hE, 0, 4'b0001, 0, 32'hE1, 0, 2));
    vq.push_back(mk(1, 0, 32'hE2, 1, 4'hF, 1, 4'b0001, 0, 32'hE2, 1, 2));
    vq.push_back(mk(0, 0, 32'h0,  0, 4'hF, 1, 4'b0000, 0, 32'h0,  0, 2));

    foreach (vq[i]) begin
      s_tvalid = vq[i].tv; s_tdest = vq[i].dest; s_tdata = vq[i].data;
      s_tlast = vq[i].last; m_tready = vq[i].mrdy;
      #1;
      check($sformatf("vec%0d_s_tready", i), 64'(s_tready), 64'(vq[i].srdy));
      tick();
      check($sformatf("vec%0d_m_tvalid", i), 64'(m_tvalid), 64'(vq[i].mv));
      if (vq[i].mv != 4'b0000) begin
        check($sformatf("vec%0d_m_tdata", i), 64'(m_tdata[vq[i].lane*DW +: DW]), 64'(vq[i].md));
        check($sformatf("vec%0d_m_tlast", i), 64'(m_tlast[vq[i].lane]), 64'(vq[i].ml));
      end
      check($sformatf("vec%0d_err_cnt", i), 64'(err_cnt), 64'(vq[i].err));
    end

    // ---------------- result merge: all four lanes at once
    do_reset();
    res_valid_in = 4'b1111; res_person_in = 4'b1010;
    for (int k = 0; k < 4; k++) res_swid_in[k*SW +: SW] = SW'(10 + k);
    tick();
    res_valid_in = '0;
    check("rr4_not_yet", 64'(res_valid_out), 64'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_res($sformatf("rr4_out%0d", k), k, 10 + k, k[0]);
    end
    tick();
    check("rr4_empty", 64'(res_valid_out), 64'd0);
    check("rr4_ovf", 64'(ovf), 64'd0);

    // round-robin resumes after the last granted lane
    res_valid_in = 4'b0010; res_person_in = '0; res_swid_in[1*SW +: SW] = SW'(20);
    tick();
    res_valid_in = '0;
    tick();
    chk_res("rr_l1", 1, 20, 1'b0);
    tick();
    res_valid_in = 4'b1001;
    res_swid_in[0*SW +: SW] = SW'(30); res_swid_in[3*SW +: SW] = SW'(33);
    tick();
    res_valid_in = '0;
    tick();
    chk_res("rr_first_l3", 3, 33, 1'b0);
    tick();
    chk_res("rr_then_l0", 0, 30, 1'b0);
    tick();
    check("rr_empty", 64'(res_valid_out), 64'd0);

    // same-cycle grant and new pulse: both results kept, no overflow
    res_valid_in = 4'b0100; res_swid_in[2*SW +: SW] = SW'(40);
    tick();
    res_swid_in[2*SW +: SW] = SW'(41);
    tick();
    res_valid_in = '0;
    chk_res("regrant_a", 2, 40, 1'b0);
    tick();
    chk_res("regrant_b", 2, 41, 1'b0);
    tick();
    check("regrant_empty", 64'(res_valid_out), 64'd0);
    check("regrant_ovf", 64'(ovf), 64'd0);

    // ---------------- randomized stream run against lane-queue model
    do_reset();
    err_exp = 0;
    done = 1'b0;
    fork
      begin
        for (int p = 0; p < 60; p++) begin
          len  = int'($urandom_range(1, 4));
          dest = int'($urandom_range(0, 5));
          if (dest >= 4) err_exp++;
          for (int b = 0; b < len; b++) begin
            d  = $urandom;
            l  = (b == len - 1);
            td = (b == 0) ? 4'(dest) : 4'($urandom);
            if (dest < 4) exp_q.push_back({2'(dest), l, d});
            repeat ($urandom_range(0, 1)) tick();
            send_beat(td, d, l);
          end
        end
        wc = 0;
        while (exp_q.size() != 0 && wc < 500) begin
          tick();
          wc++;
        end
        check("rand_drain", 64'(exp_q.size()), 64'd0);
        check("rand_err_cnt", 64'(err_cnt), 64'(err_exp));
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          m_tready = 4'($urandom) | 4'($urandom);
        end
      end
      begin
        logic [3:0]  hold_v;
        logic [32:0] hold_b [4];
        logic [34:0] e;
        bit          found;
        hold_v = '0;
        while (!done) begin
          @(negedge clk);
          for (int k = 0; k < 4; k++) begin
            if (hold_v[k]) begin
              check("rand_hold_valid", 64'(m_tvalid[k]), 64'd1);
              check("rand_hold_beat", 64'({m_tlast[k], m_tdata[k*DW +: DW]}), 64'(hold_b[k]));
            end
            hold_v[k] = m_tvalid[k] & ~m_tready[k];
            hold_b[k] = {m_tlast[k], m_tdata[k*DW +: DW]};
            if (m_tvalid[k] && m_tready[k]) begin
              found = 1'b0;
              for (int i = 0; i < exp_q.size() && !found; i++) begin
                if (exp_q[i][34:33] == 2'(k)) begin
                  e = exp_q[i];
                  exp_q.delete(i);
                  found = 1'b1;
                end
              end
              if (!found) check("rand_spurious_beat", 64'(k), 64'hFF);
              else check($sformatf("rand_lane%0d_beat", k),
                         64'({m_tlast[k], m_tdata[k*DW +: DW]}), 64'(e[32:0]));
            end
          end
        end
      end
    join
    idle_inputs();
    tick();

    // ---------------- result FIFO fill, overflow, full-with-pop drain
    do_reset();
    res_ready = 1'b0;
    res_valid_in = 4'b0010;
    for (int n = 0; n < 10; n++) begin
      res_swid_in[1*SW +: SW] = SW'(100 + n);
      tick();
    end
    res_valid_in = '0;
    check("fill_ovf", 64'(ovf), 64'b0010);
    chk_res("fill_head", 1, 100, 1'b0);
    res_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      chk_res($sformatf("drain%0d", i), 1, 100 + i, 1'b0);
      tick();
    end
    check("drain_empty", 64'(res_valid_out), 64'd0);
    check("ovf_sticky", 64'(ovf), 64'b0010);

    // ---------------- reset mid-packet with results queued
    res_ready = 1'b0;
    res_valid_in = 4'b0001; res_swid_in[0*SW +: SW] = SW'(7);
    s_tvalid = 1'b1; s_tdest = 4'd6; s_tdata = 32'hDEAD; s_tlast = 1'b0;
    tick();
    res_valid_in = '0; s_tvalid = 1'b0;
    tick();
    check("pre_rst_res_valid", 64'(res_valid_out), 64'd1);
    rst = 1'b1;
    #1;
    check("in_rst_s_tready", 64'(s_tready), 64'd0);
    check("in_rst_res_valid", 64'(res_valid_out), 64'd0);
    tick();
    rst = 1'b0;
    check("post_rst_err", 64'(err_cnt), 64'd0);
    check("post_rst_ovf", 64'(ovf), 64'd0);
    check("post_rst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("post_rst_res_valid", 64'(res_valid_out), 64'd0);
    s_tvalid = 1'b1; s_tdest = 4'd2; s_tdata = 32'hF1; s_tlast = 1'b1; m_tready = 4'hF;
    #1;
    check("post_rst_s_tready", 64'(s_tready), 64'd1);
    tick();
    s_tvalid = 1'b0;
    check("post_rst_first_beat_lane", 64'(m_tvalid), 64'b0100);
    check("post_rst_first_beat_data", 64'(m_tdata[2*DW +: DW]), 64'h0F1);
    tick();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/ip_stream_dispatcher.md
IP_STREAM_DISPATCHER -- requirements
Module: ip_stream_dispatcher

Interface
REQ-001 SHALL have parameter IP_AMT, default 4, number of image-processor lanes (range 2..16).
REQ-002 SHALL have parameter IP_ADDR_W, default $clog2(IP_AMT), lane index width.
REQ-003 SHALL have parameter AXIS_TDEST_W, default IP_ADDR_W, stream destination width.
REQ-004 SHALL have parameter AXIS_TDATA_W, default 256, pixel-group beat width.
REQ-005 SHALL have parameter SW_W, default 11, slide-window id width.
REQ-006 SHALL have parameter RES_DEPTH, default 8, result FIFO depth (power of two, >=2).
REQ-007 SHALL have port s_aclk, input, 1, the only clock.
REQ-008 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-009 SHALL have ports s_tdest_i, s_tdata_i, s_tlast_i, s_tvalid_i as inputs (AXIS_TDEST_W/AXIS_TDATA_W/1/1) and s_tready_o as a 1-bit output, forming the upstream AXI-Stream slave.
REQ-010 SHALL have outputs m_tdata_o (IP_AMT*AXIS_TDATA_W), m_tlast_o, m_tvalid_o (IP_AMT each) and input m_tready_i (IP_AMT), forming the per-lane masters; lane k uses slice k.
REQ-011 SHALL have inputs res_valid_i (IP_AMT), res_person_i (IP_AMT), res_swid_i (IP_AMT*SW_W), carrying per-lane hog_svm result pulses.
REQ-012 SHALL have outputs res_valid_o (1), res_person_o (1), res_swid_o (SW_W), res_lane_o (IP_ADDR_W) and input res_ready_i (1), forming the merged result stream.
REQ-013 SHALL have outputs err_cnt_o (16), count of discarded packets, and ovf_o (IP_AMT), sticky per-lane result-overflow flags.

Function
REQ-014 SHALL run an input FSM with states IDLE, ROUTE and SINK.
REQ-015 In IDLE, the first accepted beat SHALL latch s_tdest_i as the packet lane, then go to ROUTE if tdest<IP_AMT, else to SINK; if that beat has tlast, the FSM SHALL stay in IDLE.
REQ-016 In ROUTE/SINK, s_tdest_i SHALL be ignored; the accepted tlast beat SHALL return the FSM to IDLE.
REQ-017 Each lane SHALL hold one output register; an accepted beat SHALL appear on m_*[lane] exactly 1 cycle after acceptance (latency 1).
REQ-018 s_tready_o SHALL equal ~m_tvalid_o[lane] | m_tready_i[lane] for the current or first-beat lane in ROUTE/IDLE, and 1 in SINK or for an out-of-range tdest in IDLE.
REQ-019 m_tvalid_o[k] SHALL stay high with stable data/last until m_tready_i[k]=1; a simultaneous drain and refill SHALL keep m_tvalid_o[k] high with new data.
REQ-020 Beats in SINK and the first beat of an out-of-range packet SHALL be accepted and discarded.
REQ-021 err_cnt_o SHALL increment once per discarded packet (on its first beat) and saturate at 16'hFFFF.
REQ-022 Each lane SHALL have a 1-entry pending capture register for {person, swid}, loaded when res_valid_i[k]=1.
REQ-023 If res_valid_i[k]=1 while pending[k] is set and not being granted that cycle, the new result SHALL be dropped and ovf_o[k] set; a same-cycle grant and new pulse SHALL capture the new result with no overflow.
REQ-024 A round-robin arbiter SHALL grant at most one pending lane per cycle into the result FIFO when the FIFO is not full; priority SHALL start at the lane after the last grant, with lane 0 first after reset.
REQ-025 The result FIFO SHALL be first-word-fall-through: res_valid_o = not empty, and {res_lane_o, res_person_o, res_swid_o} SHALL be the head entry; a pop occurs on res_valid_o & res_ready_i.
REQ-026 When the FIFO is full and a pop occurs, a grant SHALL be allowed in the same cycle; when the FIFO is empty, an entry SHALL appear on res_valid_o 1 cycle after its grant.
REQ-027 Result latency from res_valid_i to res_valid_o SHALL be 2 cycles with no contention and an empty FIFO.

Reset
REQ-028 While rst=1 at a rising edge: FSM->IDLE, all m_tvalid_o=0, pending=0, FIFO empty, arbiter pointer=0, err_cnt_o=0, ovf_o=0.
REQ-029 During reset, s_tready_o SHALL be 0 and res_valid_o SHALL be 0; a packet in flight SHALL be abandoned and the next beat after reset treated as a first beat.

Verification
REQ-030 Send 3-beat packet tdest=2, m_tready_i all 1 -> beats appear on lane 2 only, one cycle later each, m_tlast_o[2] on beat 3.
REQ-031 Send 2-beat packet, beat 1 tdest=1, beat 2 tdest=3 -> both beats delivered on lane 1.
REQ-032 Send 4-beat packet tdest=5 with IP_AMT=4 -> s_tready_o=1 on all beats, no m_tvalid_o, err_cnt_o goes 0->1.
REQ-033 Hold m_tready_i[0]=0, send 2 beats to lane 0 -> first beat held, s_tready_o=0 until m_tready_i[0]=1, no data lost.
REQ-034 Pulse res_valid_i=4'b1111 with swid 10,11,12,13 and res_ready_i=1 -> outputs lanes 0,1,2,3 in order on consecutive cycles, ovf_o=0.
REQ-035 Hold res_ready_i=0, pulse lane 1 RES_DEPTH+2 times -> FIFO holds 8 entries, pending holds 1, ovf_o[1]=1; assert rst -> all outputs return to reset values.
